result_ascii_stream: RTL

Downstream formatter for the Euler solver cores: consumes a solver's binary `result`/`done`/`error` outputs and streams the answer as ASCII decimal text, one byte per handshake, toward the UART transmitter. Conversion is sequential double-dabble, one bit per cycle. It replaces the testbench `$display` path so results are observable on hardware.

---
 rtl/result_ascii_stream.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/result_ascii_stream.sv
// Converts a solver's binary result to ASCII decimal text using sequential double-dabble.
// It streams one byte per valid/ready handshake and terminates the text with CR LF; a solver error produces "ERR\r\n".
module result_ascii_stream #(
    parameter int IN_W   = 40,
    parameter int DIGITS = 13
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [IN_W-1:0] result,
    input  logic            done,
    input  logic            error,
    output logic [7:0]      tx_data,
    output logic            tx_valid,
    input  logic            tx_ready,
    output logic            busy,
    output logic            finished
);

    localparam int PTR_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = $clog2(IN_W + 1);
    localparam int BCD_W = 4 * DIGITS;
    localparam logic [PTR_W-1:0] PTR_MS   = PTR_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CONVERT  = 3'd1,
        SCAN     = 3'd2,
        EMIT_NUM = 3'd3,
        EMIT_ERR = 3'd4,
        FINISH   = 3'd5
    } state_t;

    // Add 3 to every nibble >= 5 before the shift; 4-bit add, no carry out
    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] adj;
        adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? (bcd[4*i +: 4] + 4'd3) : bcd[4*i +: 4];
        end
        return adj;
    endfunction

    function automatic logic [3:0] bcd_digit(input logic [BCD_W-1:0] bcd, input logic [PTR_W-1:0] idx);
        logic [3:0] d;
        d = 4'h0;
        for (int i = 0; i < DIGITS; i++) begin
            d = (idx == PTR_W'(i)) ? bcd[4*i +: 4] : d;
        end
        return d;
    endfunction

    function automatic logic [7:0] err_byte(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = 8'h45;
            3'd1:    b = 8'h52;
            3'd2:    b = 8'h52;
            3'd3:    b = 8'h0D;
            default: b = 8'h0A;
        endcase
        return b;
    endfunction

    state_t            state_r, state_s;
    logic [IN_W-1:0]   shift_r, shift_s;
    logic [BCD_W-1:0]  bcd_r, bcd_s, adj_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [PTR_W-1:0]  ptr_r, ptr_s, ptr_dec_s;
    logic [1:0]        phase_r, phase_s;
    logic [2:0]        err_idx_r, err_idx_s;
    logic [7:0]        tx_data_r, tx_data_s;
    logic              tx_valid_r, tx_valid_s;
    logic              busy_r, busy_s;
    logic              finished_r, finished_s;
    logic              xfer_s;
    logic [3:0]        digit_s, digit_lo_s;

    assign xfer_s     = tx_valid_r & tx_ready;
    assign adj_s      = bcd_adjust(bcd_r);
    assign ptr_dec_s  = ptr_r - PTR_W'(1);
    assign digit_s    = bcd_digit(bcd_r, ptr_r);
    assign digit_lo_s = bcd_digit(bcd_r, ptr_dec_s);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (error) begin
                    state_s = EMIT_ERR;
                end else if (done) begin
                    state_s = CONVERT;
                end else begin
                    state_s = IDLE;
                end
            end
            CONVERT: begin
                if (cnt_r == CNT_LAST) begin
                    state_s = SCAN;
                end else begin
                    state_s = CONVERT;
                end
            end
            SCAN: begin
                if ((digit_s != 4'd0) || (ptr_r == PTR_W'(0))) begin
                    state_s = EMIT_NUM;
                end else begin
                    state_s = SCAN;
                end
            end
            EMIT_NUM: begin
                if (xfer_s && (phase_r == 2'd2)) begin
                    state_s = FINISH;
                end else begin
                    state_s = EMIT_NUM;
                end
            end
            EMIT_ERR: begin
                if (xfer_s && (err_idx_r == 3'd4)) begin
                    state_s = FINISH;
                end else begin
                    state_s = EMIT_ERR;
                end
            end
            FINISH:  state_s = FINISH;
            default: state_s = IDLE;
        endcase
    end

    // Datapath and output next values; the outputs themselves are registered below
    always_comb begin
        shift_s    = shift_r;
        bcd_s      = bcd_r;
        cnt_s      = cnt_r;
        ptr_s      = ptr_r;
        phase_s    = phase_r;
        err_idx_s  = err_idx_r;
        tx_data_s  = tx_data_r;
        tx_valid_s = tx_valid_r;
        busy_s     = busy_r;
        finished_s = finished_r;
        case (state_r)
            IDLE: begin
                if (error) begin
                    busy_s    = 1'b1;
                    err_idx_s = 3'd0;
                end else if (done) begin
                    shift_s = result;
                    bcd_s   = {BCD_W{1'b0}};
                    cnt_s   = {CNT_W{1'b0}};
                    busy_s  = 1'b1;
                end else begin
                    busy_s = 1'b0;
                end
            end
            CONVERT: begin
                {bcd_s, shift_s} = {adj_s[BCD_W-2:0], shift_r, 1'b0};
                cnt_s = cnt_r + CNT_W'(1);
                if (cnt_r == CNT_LAST) begin
                    ptr_s = PTR_MS;
                end else begin
                    ptr_s = ptr_r;
                end
            end
            SCAN: begin
                if ((digit_s == 4'd0) && (ptr_r != PTR_W'(0))) begin
                    ptr_s = ptr_dec_s;
                end else begin
                    tx_valid_s = 1'b1;
                    tx_data_s  = 8'h30 + {4'h0, digit_s};
                    phase_s    = 2'd0;
                end
            end
            EMIT_NUM: begin
                if (xfer_s) begin
                    case (phase_r)
                        2'd0: begin
                            if (ptr_r == PTR_W'(0)) begin
                                phase_s   = 2'd1;
                                tx_data_s = 8'h0D;
                            end else begin
                                ptr_s     = ptr_dec_s;
                                tx_data_s = 8'h30 + {4'h0, digit_lo_s};
                            end
                        end
                        2'd1: begin
                            phase_s   = 2'd2;
                            tx_data_s = 8'h0A;
                        end
                        default: begin
                            tx_valid_s = 1'b0;
                            tx_data_s  = 8'h00;
                            busy_s     = 1'b0;
                            finished_s = 1'b1;
                        end
                    endcase
                end else begin
                    tx_data_s = tx_data_r;
                end
            end
            EMIT_ERR: begin
                // First cycle in this state loads the leading 'E'
                if (!tx_valid_r) begin
                    tx_valid_s = 1'b1;
                    tx_data_s  = err_byte(3'd0);
                end else if (xfer_s) begin
                    if (err_idx_r == 3'd4) begin
                        tx_valid_s = 1'b0;
                        tx_data_s  = 8'h00;
                        busy_s     = 1'b0;
                        finished_s = 1'b1;
                    end else begin
                        err_idx_s = err_idx_r + 3'd1;
                        tx_data_s = err_byte(err_idx_r + 3'd1);
                    end
                end else begin
                    tx_data_s = tx_data_r;
                end
            end
            FINISH: begin
                tx_valid_s = 1'b0;
                busy_s     = 1'b0;
                finished_s = 1'b1;
            end
            default: begin
                tx_valid_s = 1'b0;
                busy_s     = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_r    <= {IN_W{1'b0}};
            bcd_r      <= {BCD_W{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            ptr_r      <= {PTR_W{1'b0}};
            phase_r    <= 2'd0;
            err_idx_r  <= 3'd0;
            tx_data_r  <= 8'h00;
            tx_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            finished_r <= 1'b0;
        end else begin
            shift_r    <= shift_s;
            bcd_r      <= bcd_s;
            cnt_r      <= cnt_s;
            ptr_r      <= ptr_s;
            phase_r    <= phase_s;
            err_idx_r  <= err_idx_s;
            tx_data_r  <= tx_data_s;
            tx_valid_r <= tx_valid_s;
            busy_r     <= busy_s;
            finished_r <= finished_s;
        end
    end

    assign tx_data  = tx_data_r;
    assign tx_valid = tx_valid_r;
    assign busy     = busy_r;
    assign finished = finished_r;

endmodule
